apb_slave_mem: RTL and testbench

APB completer that sits directly downstream of the team's APB master. It decodes paddr into a word-addressed register array, services read and write transfers, and inserts a fixed number of wait states via pready. It flags out-of-range addresses with pslverr. It is the first memory-mapped target on the bus and is the standard endpoint for master-level verification.

---
 rtl/apb_slave_mem_if.sv | 31 +++
 rtl/apb_slave_mem.sv | 159 +++++++++++++++
 tb/tb_apb_slave_mem.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_mem_if.sv
// ============================================================================
// apb_slave_mem_if : APB bus bundle between the master and apb_slave_mem.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pselx;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output paddr, pselx, penable, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pselx, penable, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

`default_nettype wire

// File: rtl/apb_slave_mem.sv
// ============================================================================
// apb_slave_mem : APB completer backed by a word-addressed register array,
//                 fixed wait states, pslverr on out-of-range addresses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  apb_slave_mem_if.slave   bus
);

  localparam int                  IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [3:0]          CNT_LOAD  = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_write;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_addr_oor;
  logic                  w_setup;
  logic                  w_complete;
  logic                  w_commit;
  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_rd_err;
  logic                  w_rd_write;
  logic                  w_pready_nxt;
  logic                  w_pslverr_nxt;
  logic [DATA_WIDTH-1:0] w_prdata_nxt;

  // Upper paddr bits feed only this range check; the array uses the low IDX_W bits.
  assign w_addr_oor = ({1'b0, bus.paddr} >= MEM_LIMIT);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_setup       = 1'b0;
    w_complete    = 1'b0;
    w_commit      = 1'b0;
    w_rd_idx      = r_idx;
    w_rd_err      = r_err;
    w_rd_write    = r_write;
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;
    w_prdata_nxt  = '0;

    case (r_state)
      ST_IDLE: begin
        // A select with penable already high has no setup phase and is ignored.
        if (bus.pselx && !bus.penable) begin
          w_setup    = 1'b1;
          w_rd_idx   = bus.paddr[IDX_W-1:0];
          w_rd_err   = w_addr_oor;
          w_rd_write = bus.pwrite;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ST_READY;
            w_complete  = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.pselx) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = ST_READY;
          w_complete  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_IDLE;
        w_commit    = r_write && !r_err;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_complete) begin
      w_pready_nxt  = 1'b1;
      w_pslverr_nxt = w_rd_err;
      if (!w_rd_write && !w_rd_err) begin
        w_prdata_nxt = r_mem[w_rd_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_wdata   <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_prdata  <= w_prdata_nxt;
      if (w_setup) begin
        r_idx   <= bus.paddr[IDX_W-1:0];
        r_write <= bus.pwrite;
        r_err   <= w_addr_oor;
        r_wdata <= bus.pwdata;
      end
    end
  end

  // Write lands on the edge closing the READY cycle, before any following setup.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;
  assign bus.prdata  = r_prdata;

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
// ============================================================================
// tb_apb_slave_mem : directed self-checking bench for apb_slave_mem.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb_slave_mem;

  logic clk;
  logic resetn;
  int   tests;
  int   fails;

  apb_slave_mem_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();
  apb_slave_mem_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus0 ();

  apb_slave_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_CYCLES(2)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  apb_slave_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One transfer on the WAIT_CYCLES=2 instance. Address and data are scrambled
  // during the access phase; the DUT must use the setup-phase values.
  task automatic xfer(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int nwait);
    logic done;
    bus.pselx   = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = wdata;
    @(posedge clk);
    #1;
    bus.penable = 1'b1;
    bus.paddr   = ~addr;
    bus.pwdata  = ~wdata;
    nwait = 0;
    done  = 1'b0;
    rdata = 'x;
    err   = 1'bx;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.pready === 1'b1) begin
        done  = 1'b1;
        rdata = bus.prdata;
        err   = bus.pslverr;
      end else begin
        nwait++;
      end
    end
    chk("pready_seen", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    bus.pselx   = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    @(negedge clk);
    chk("pready_one_cycle", {31'd0, bus.pready}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          nw;
  logic        seen;

  initial begin
    tests = 0;
    fails = 0;
    resetn = 1'b0;
    bus.pselx = 1'b0;  bus.penable = 1'b0;  bus.pwrite = 1'b0;  bus.paddr = '0;  bus.pwdata = '0;
    bus0.pselx = 1'b0; bus0.penable = 1'b0; bus0.pwrite = 1'b0; bus0.paddr = '0; bus0.pwdata = '0;
    idle(3);
    chk("rst_pready",  {31'd0, bus.pready},  32'd0);
    chk("rst_prdata",  bus.prdata,           32'd0);
    chk("rst_pslverr", {31'd0, bus.pslverr}, 32'd0);
    resetn = 1'b1;
    idle(2);

    // Read of a cleared word, two wait states
    xfer(1'b0, 10'h005, 32'h0, rd, er, nw);
    chk("rd005_waits", 32'(nw), 32'd2);
    chk("rd005_data",  rd, 32'h0000_0000);
    chk("rd005_err",   {31'd0, er}, 32'd0);
    idle(1);

    // Write then read back
    xfer(1'b1, 10'h010, 32'hDEAD_BEEF, rd, er, nw);
    chk("wr010_waits", 32'(nw), 32'd2);
    chk("wr010_err",   {31'd0, er}, 32'd0);
    xfer(1'b0, 10'h010, 32'h0, rd, er, nw);
    chk("rd010_data",  rd, 32'hDEAD_BEEF);
    chk("rd010_err",   {31'd0, er}, 32'd0);
    idle(1);

    // Out-of-range write must not alias onto word 0
    xfer(1'b1, 10'h100, 32'h1234_5678, rd, er, nw);
    chk("wr100_err",   {31'd0, er}, 32'd1);
    xfer(1'b0, 10'h000, 32'h0, rd, er, nw);
    chk("rd000_data",  rd, 32'h0);
    chk("rd000_err",   {31'd0, er}, 32'd0);
    xfer(1'b0, 10'h100, 32'h0, rd, er, nw);
    chk("rd100_data",  rd, 32'h0);
    chk("rd100_err",   {31'd0, er}, 32'd1);
    idle(1);

    // Back-to-back writes and reads, no idle cycles
    xfer(1'b1, 10'h001, 32'hA5A5_A5A5, rd, er, nw);
    xfer(1'b1, 10'h002, 32'h5A5A_5A5A, rd, er, nw);
    xfer(1'b0, 10'h001, 32'h0, rd, er, nw);
    chk("b2b_rd001", rd, 32'hA5A5_A5A5);
    xfer(1'b0, 10'h002, 32'h0, rd, er, nw);
    chk("b2b_rd002", rd, 32'h5A5A_5A5A);
    chk("b2b_waits", 32'(nw), 32'd2);
    idle(1);

    // Zero-wait instance: pready in the first access cycle
    bus0.pselx = 1'b1; bus0.penable = 1'b0; bus0.pwrite = 1'b1;
    bus0.paddr = 10'h003; bus0.pwdata = 32'h1111_1111;
    @(posedge clk); #1; bus0.penable = 1'b1;
    @(negedge clk);
    chk("w0_wr_pready",  {31'd0, bus0.pready},  32'd1);
    chk("w0_wr_pslverr", {31'd0, bus0.pslverr}, 32'd0);
    @(posedge clk); #1;
    bus0.penable = 1'b0; bus0.pwrite = 1'b0;
    @(posedge clk); #1; bus0.penable = 1'b1;
    @(negedge clk);
    chk("w0_rd_pready", {31'd0, bus0.pready}, 32'd1);
    chk("w0_rd_prdata", bus0.prdata, 32'h1111_1111);
    @(posedge clk); #1;
    bus0.pselx = 1'b0; bus0.penable = 1'b0;
    @(negedge clk);
    chk("w0_pready_drop", {31'd0, bus0.pready}, 32'd0);

    // pselx dropped during WAIT aborts the write
    bus.pselx = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 10'h020; bus.pwdata = 32'hCAFE_F00D;
    @(posedge clk); #1; bus.penable = 1'b1;
    @(posedge clk); #1; bus.pselx = 1'b0; bus.penable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.pready !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_pready", {31'd0, seen}, 32'd0);
    xfer(1'b0, 10'h020, 32'h0, rd, er, nw);
    chk("abort_rd020", rd, 32'h0);
    idle(1);

    // Reset during WAIT of a write
    bus.pselx = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 10'h030; bus.pwdata = 32'hFFFF_FFFF;
    @(posedge clk); #1; bus.penable = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rstw_pready",  {31'd0, bus.pready},  32'd0);
    chk("rstw_pslverr", {31'd0, bus.pslverr}, 32'd0);
    bus.pselx = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    @(posedge clk); #1; resetn = 1'b1;
    idle(1);
    xfer(1'b0, 10'h030, 32'h0, rd, er, nw);
    chk("rstw_rd030", rd, 32'h0);
    idle(1);

    // Reset while a read response is on the bus clears outputs and memory at once
    xfer(1'b1, 10'h040, 32'h0BAD_F00D, rd, er, nw);
    bus.pselx = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 10'h040;
    @(posedge clk); #1; bus.penable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.pready === 1'b1) seen = 1'b1;
    end
    chk("rstr_pready_hi", {31'd0, seen}, 32'd1);
    chk("rstr_prdata_hi", bus.prdata, 32'h0BAD_F00D);
    resetn = 1'b0;
    #1;
    chk("rstr_pready_lo", {31'd0, bus.pready}, 32'd0);
    chk("rstr_prdata_lo", bus.prdata, 32'h0);
    bus.pselx = 1'b0; bus.penable = 1'b0;
    @(posedge clk); #1; resetn = 1'b1;
    idle(1);
    xfer(1'b0, 10'h040, 32'h0, rd, er, nw);
    chk("rstr_rd040", rd, 32'h0);
    xfer(1'b0, 10'h010, 32'h0, rd, er, nw);
    chk("rstr_rd010", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
